// File: rtl/dsp_pkg.sv
// dsp_pkg: shared pre-adder mode encodings and B input source names for the DSP input stage.
package dsp_pkg;
    localparam logic [1:0] PRE_B   = 2'b00;
    localparam logic [1:0] PRE_DPB = 2'b01;
    localparam logic [1:0] PRE_DMB = 2'b10;
    localparam logic [1:0] PRE_BMD = 2'b11;
    localparam string B_DIRECT  = "DIRECT";
    localparam string B_CASCADE = "CASCADE";
endpackage

// File: rtl/dsp_preadd.sv
// dsp_preadd: signed B/D pre-adder at B_W+1 bits with overflow flag.
// DSP_PREADD_SAT_EN defined clamps overflowing results; otherwise the low B_W bits wrap.
module dsp_preadd import dsp_pkg::*; #(
    parameter int B_W = 18,
    parameter int D_W = 18
) (
    input  logic [B_W-1:0] b,
    input  logic [D_W-1:0] d,
    input  logic [1:0]     mode,
    output logic [B_W-1:0] res,
    output logic           ovf
);
    logic [B_W:0] bx, dx, full;
    always_comb begin
        bx   = {b[B_W-1], b};
        dx   = {{(B_W+1-D_W){d[D_W-1]}}, d};
        full = (mode == PRE_B)   ? bx :
               (mode == PRE_DPB) ? dx + bx :
               (mode == PRE_BMD) ? bx - dx : dx - bx;
        // The extra top bit disagreeing with the B_W sign bit means the result left the B_W range
        ovf  = full[B_W] != full[B_W-1];
`ifdef DSP_PREADD_SAT_EN
        res  = !ovf ? full[B_W-1:0] :
               full[B_W] ? {1'b1, {(B_W-1){1'b0}}} : {1'b0, {(B_W-1){1'b1}}};
`else
        res  = full[B_W-1:0];
`endif
    end
endmodule

// File: rtl/dsp_prestage_pipe.sv
// dsp_prestage_pipe: 2-stage DSP input/pre-adder pipeline with valid/ready backpressure.
// Optional clamping of the pre-add result is enabled by defining DSP_PREADD_SAT_EN.
module dsp_prestage_pipe import dsp_pkg::*; #(
    parameter int    A_W     = 18,
    parameter int    B_W     = 18,
    parameter int    D_W     = 18,
    parameter int    C_W     = 48,
    parameter string B_INPUT = "DIRECT"
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           clr,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [A_W-1:0] a,
    input  logic [B_W-1:0] b,
    input  logic [B_W-1:0] bcin,
    input  logic [D_W-1:0] d,
    input  logic [C_W-1:0] c,
    input  logic [1:0]     pre_mode,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [A_W-1:0] a1,
    output logic [B_W-1:0] b1,
    output logic [C_W-1:0] c_out,
    output logic [D_W-1:0] d_out,
    output logic [B_W-1:0] bcout,
    output logic           ovf
);
    localparam bit USE_CASCADE = (B_INPUT == B_CASCADE);

    if (B_INPUT != B_DIRECT && B_INPUT != B_CASCADE) begin : g_bad_b_input
        $error("B_INPUT must be DIRECT or CASCADE");
    end
    if (D_W > B_W) begin : g_bad_d_w
        $error("D_W must not exceed B_W");
    end

    logic           v0, v1, adv0, adv1, ld0, ld1, pre_ovf;
    logic [A_W-1:0] a0;
    logic [B_W-1:0] b0, bsel, pre;
    logic [D_W-1:0] d0;
    logic [C_W-1:0] c0;
    logic [1:0]     m0;

    assign adv1      = !v1 || out_ready;
    assign adv0      = !v0 || adv1;
    assign in_ready  = adv0;
    assign out_valid = v1;
    assign bcout     = b0;
    assign bsel      = USE_CASCADE ? bcin : b;
    // Data only moves with a real beat so bubbles never overwrite held operands
    assign ld0       = adv0 && in_valid;
    assign ld1       = adv1 && v0;

    dsp_preadd #(.B_W(B_W), .D_W(D_W)) u_preadd (
        .b(b0), .d(d0), .mode(m0), .res(pre), .ovf(pre_ovf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || clr) begin
            v0 <= 1'b0;
            a0 <= '0;
            b0 <= '0;
            d0 <= '0;
            c0 <= '0;
            m0 <= '0;
        end else begin
            if (adv0) v0 <= in_valid;
            if (ld0) begin
                a0 <= a;
                b0 <= bsel;
                d0 <= d;
                c0 <= c;
                m0 <= pre_mode;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || clr) begin
            v1    <= 1'b0;
            a1    <= '0;
            b1    <= '0;
            c_out <= '0;
            d_out <= '0;
            ovf   <= 1'b0;
        end else begin
            if (adv1) v1 <= v0;
            if (ld1) begin
                a1    <= a0;
                b1    <= pre;
                c_out <= c0;
                d_out <= d0;
                ovf   <= pre_ovf;
            end
        end
    end
endmodule

// File: tb/tb_dsp_prestage_pipe.sv
// tb_dsp_prestage_pipe: directed plus random checks of dsp_prestage_pipe against an integer reference model.
module tb_dsp_prestage_pipe;
    localparam int MAXP = 131071;
    localparam int MINN = -131072;

    typedef struct {
        logic [17:0] a;
        logic [17:0] b1;
        logic [17:0] d;
        logic [47:0] c;
        logic        ovf;
    } exp_t;

    logic        clk = 0, rst_n = 0, clr = 0, in_valid = 0, out_ready = 1;
    logic [17:0] a = 0, b = 0, bcin = 0, d = 0;
    logic [47:0] c = 0;
    logic [1:0]  pre_mode = 0;
    logic        in_ready, out_valid, ovf, in_ready_c, out_valid_c, ovf_c;
    logic [17:0] a1, b1, d_out, bcout, a1_c, b1_c, d_out_c, bcout_c;
    logic [47:0] c_out, c_out_c;

    int   n_tests = 0, n_fail = 0, n_out = 0;
    bit   last_acc, held, saw_full;
    exp_t q[$];
    exp_t snap;

    always #5 clk = ~clk;

    dsp_prestage_pipe dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .bcin(bcin), .d(d), .c(c), .pre_mode(pre_mode),
        .out_valid(out_valid), .out_ready(out_ready), .a1(a1), .b1(b1), .c_out(c_out),
        .d_out(d_out), .bcout(bcout), .ovf(ovf)
    );

    dsp_prestage_pipe #(.B_INPUT("CASCADE")) dut_c (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready_c),
        .a(a), .b(b), .bcin(bcin), .d(d), .c(c), .pre_mode(pre_mode),
        .out_valid(out_valid_c), .out_ready(out_ready), .a1(a1_c), .b1(b1_c), .c_out(c_out_c),
        .d_out(d_out_c), .bcout(bcout_c), .ovf(ovf_c)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [17:0] ai, input logic [17:0] bi,
                                   input logic [17:0] di, input logic [47:0] ci, input logic [1:0] m);
        exp_t e;
        int bv, dv, full, r;
        bv = int'($signed(bi));
        dv = int'($signed(di));
        full = (m == 2'd0) ? bv : (m == 2'd1) ? dv + bv : (m == 2'd2) ? dv - bv : bv - dv;
        e.ovf = (full > MAXP) || (full < MINN);
`ifdef DSP_PREADD_SAT_EN
        r = (full > MAXP) ? MAXP : (full < MINN) ? MINN : full;
`else
        r = full;
`endif
        e.b1 = r[17:0];
        e.a = ai;
        e.d = di;
        e.c = ci;
        return e;
    endfunction

    // One clock: observe handshakes mid-cycle, update the scoreboard, then step past the edge
    task automatic tick();
        exp_t e;
        @(negedge clk);
        last_acc = 0;
        if (clr) begin
            q.delete();
            held = 0;
        end else begin
            chk("in_ready", in_ready, !(q.size() == 2 && !out_ready));
            if (!in_ready) saw_full = 1;
            if (held) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_b1", b1, snap.b1);
                chk("hold_c", c_out, snap.c);
            end
            if (out_valid && out_ready) begin
                n_out++;
                if (q.size() == 0) chk("spurious_out", out_valid, 0);
                else begin
                    e = q.pop_front();
                    chk("a1", a1, e.a);
                    chk("b1", b1, e.b1);
                    chk("c_out", c_out, e.c);
                    chk("d_out", d_out, e.d);
                    chk("ovf", ovf, e.ovf);
                end
            end
            held = out_valid && !out_ready;
            snap.b1 = b1;
            snap.c = c_out;
            if (in_valid && in_ready) begin
                q.push_back(model(a, b, d, c, pre_mode));
                last_acc = 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_one(input logic [17:0] ai, input logic [17:0] bi,
                            input logic [17:0] di, input logic [1:0] m);
        a = ai; b = bi; d = di; pre_mode = m; c = {$urandom, $urandom};
        in_valid = 1; out_ready = 1;
        tick();
        in_valid = 0;
        tick();
    endtask

    initial begin
        exp_t sb[5];
        int k, sent;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_data", {a1, b1, d_out, bcout, ovf}, 0);
        chk("rst_c", c_out, 0);

        send_one(18'd3, 18'd7, 18'd5, 2'b01);
        chk("lat_valid", out_valid, 1);
        chk("lat_b1", b1, 12);
        chk("lat_a1", a1, 3);
        chk("lat_ovf", ovf, 0);
        tick();

        send_one(18'd1, 18'd1, 18'h1FFFF, 2'b01);
        chk("ovf_pos", ovf, 1);
`ifdef DSP_PREADD_SAT_EN
        chk("ovf_pos_b1", b1, 18'h1FFFF);
`else
        chk("ovf_pos_b1", b1, 18'h20000);
`endif
        tick();
        send_one(18'd2, 18'h20000, 18'd1, 2'b11);
        chk("ovf_neg", ovf, 1);
`ifdef DSP_PREADD_SAT_EN
        chk("ovf_neg_b1", b1, 18'h20000);
`else
        chk("ovf_neg_b1", b1, 18'h1FFFF);
`endif
        tick();
        send_one(18'd4, 18'h20000, 18'h1FFFF, 2'b00);
        chk("mode0_no_ovf", ovf, 0);
        tick();

        // five-beat stream with a three-cycle downstream stall
        for (int i = 0; i < 5; i++) begin
            sb[i].a = 18'(i + 10); sb[i].b1 = 18'(i * 3); sb[i].d = 18'(i + 100);
        end
        n_out = 0; sent = 0; k = 0; saw_full = 0;
        while ((sent < 5 || q.size() > 0) && k < 100) begin
            out_ready = !(k >= 3 && k <= 5);
            in_valid = sent < 5;
            if (sent < 5) begin
                a = sb[sent].a; b = sb[sent].b1; d = sb[sent].d; pre_mode = 2'(sent);
                c = 48'(sent + 1000);
            end
            tick();
            if (last_acc) sent++;
            k++;
        end
        in_valid = 0; out_ready = 1;
        chk("stream_timeout", k < 100, 1);
        chk("stream_count", n_out, 5);
        chk("stream_full_seen", saw_full, 1);

        for (int i = 0; i < 300; i++) begin
            in_valid = ($urandom % 4) != 0;
            out_ready = ($urandom % 3) != 0;
            a = 18'($urandom); b = 18'($urandom); bcin = 18'($urandom);
            d = 18'($urandom); c = {$urandom, $urandom}; pre_mode = 2'($urandom);
            tick();
        end
        in_valid = 0; out_ready = 1;
        repeat (4) tick();
        chk("rand_drained", q.size(), 0);

        // cascade source, then clear while stalled
        bcin = 18'd9; b = 18'd4; d = 18'd0; pre_mode = 2'b00; a = 18'd6; in_valid = 1;
        tick();
        in_valid = 0;
        chk("bcout_cascade", bcout_c, 9);
        chk("bcout_direct", bcout, 4);
        tick();
        chk("casc_valid", out_valid_c, 1);
        chk("casc_b1", b1_c, 9);
        out_ready = 0; in_valid = 1; a = 18'd8;
        tick();
        in_valid = 0;
        chk("stall_valid", out_valid, 1);
        clr = 1;
        tick();
        clr = 0;
        chk("clr_valid", out_valid, 0);
        chk("clr_valid_c", out_valid_c, 0);
        chk("clr_in_ready", in_ready, 1);
        chk("clr_data", {a1, b1, d_out, bcout, ovf}, 0);
        chk("clr_data_c", {a1_c, b1_c, d_out_c, bcout_c, ovf_c}, 0);
        chk("clr_c", c_out | c_out_c, 0);
        out_ready = 1;
        tick();
        chk("clr_no_beat", out_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
